// File: rtl/ysyx_25030077_ifu.sv
// Instruction fetch unit for the ysyx_25030077 multi-cycle RV32 core.
// Owns the PC, issues one instruction fetch at a time over a valid/ready
// request/response pair, hands the word and its PC to decode, and loads the
// next PC computed downstream. HALT and FAULT are terminal until reset.
module ysyx_25030077_ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clock,
  input  logic        reset,
  output logic        io_imem_req_valid,
  input  logic        io_imem_req_ready,
  output logic [31:0] io_imem_req_addr,
  input  logic        io_imem_resp_valid,
  input  logic [31:0] io_imem_resp_data,
  input  logic        io_imem_resp_err,
  output logic        io_inst_valid,
  input  logic        io_inst_ready,
  output logic [31:0] io_instruction,
  output logic [31:0] io_pc_count,
  input  logic        io_pc_next_valid,
  input  logic [31:0] io_pc_next,
  input  logic        io_halt,
  output logic        io_fetch_fault,
  output logic        io_halted,
  output logic [31:0] io_fetch_count
);

  // Instruction register contents after reset: addi x0, x0, 0
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [2:0] {
    S_BOOT    = 3'd0,
    S_REQ     = 3'd1,
    S_WAIT    = 3'd2,
    S_DELIVER = 3'd3,
    S_EXEC    = 3'd4,
    S_HALT    = 3'd5,
    S_FAULT   = 3'd6
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] r_inst;
  logic [31:0] r_fetch_cnt;

  logic        w_resp_ok;
  logic        w_deliver_fire;
  logic        w_pc_misaligned;
  logic        w_pc_load;

  // A target is fetchable only when it sits on a 4-byte boundary.
  function automatic logic f_misaligned(input logic [31:0] addr);
    return (addr[1:0] != 2'b00);
  endfunction

  // Qualified events; every one of them is gated by the state that owns it,
  // so stray pulses in other states have no effect.
  assign w_resp_ok       = (r_state == S_WAIT) && io_imem_resp_valid && !io_imem_resp_err;
  assign w_deliver_fire  = (r_state == S_DELIVER) && io_inst_ready;
  assign w_pc_misaligned = f_misaligned(io_pc_next);
  assign w_pc_load       = (r_state == S_EXEC) && io_pc_next_valid && !io_halt && !w_pc_misaligned;

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= S_BOOT;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic; halt is checked before alignment so an ebreak with a
  // garbage next PC still ends in HALT.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_BOOT:    w_state_nxt = S_REQ;
      S_REQ:     if (io_imem_req_ready) w_state_nxt = S_WAIT;
      S_WAIT:    if (io_imem_resp_valid) w_state_nxt = io_imem_resp_err ? S_FAULT : S_DELIVER;
      S_DELIVER: if (io_inst_ready) w_state_nxt = S_EXEC;
      S_EXEC: begin
        if (io_pc_next_valid) begin
          if (io_halt)              w_state_nxt = S_HALT;
          else if (w_pc_misaligned) w_state_nxt = S_FAULT;
          else                      w_state_nxt = S_REQ;
        end
      end
      S_HALT:    w_state_nxt = S_HALT;
      S_FAULT:   w_state_nxt = S_FAULT;
      default:   w_state_nxt = S_BOOT;
    endcase
  end

  // Architectural PC; only an accepted, aligned, non-halting next PC loads it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)         r_pc <= RESET_PC;
    else if (w_pc_load) r_pc <= io_pc_next;
  end

  // Instruction register; captured from a good response while waiting.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)         r_inst <= NOP_INST;
    else if (w_resp_ok) r_inst <= io_imem_resp_data;
  end

  // Delivered-instruction counter; wraps naturally at 2^32.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)              r_fetch_cnt <= 32'd0;
    else if (w_deliver_fire) r_fetch_cnt <= r_fetch_cnt + 32'd1;
  end

  // Outputs are state decodes or register copies only, so no input reaches
  // an output within the same cycle.
  assign io_imem_req_valid = (r_state == S_REQ);
  assign io_imem_req_addr  = r_pc;
  assign io_inst_valid     = (r_state == S_DELIVER);
  assign io_instruction    = r_inst;
  assign io_pc_count       = r_pc;
  assign io_fetch_fault    = (r_state == S_FAULT);
  assign io_halted         = (r_state == S_HALT);
  assign io_fetch_count    = r_fetch_cnt;

endmodule
